// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access stage.
//  control_t     : decoded control bundle carried down the pipe; this stage reads
//                  .mem_read, .mem_write and .mem_funct3 and forwards the rest untouched.
//  F3_*          : load/store funct3 encodings.
//  mem_state_e   : stage FSM states.
//  exc_cause_e   : fault codes reported on exc_cause_o.
//  is_misaligned : access-size alignment check from funct3 and address low bits.
package mem_access_pkg;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_funct3;
    } control_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Bubble-equivalent instruction shown on control_o out of reset.
    localparam control_t MI_ADDI = '{
        reg_write:  1'b1,
        alu_src:    1'b1,
        alu_op:     4'd0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_funct3: 3'b000
    };

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } mem_state_e;

    typedef enum logic [1:0] {
        ExcLoadMisaligned  = 2'd0,
        ExcStoreMisaligned = 2'd1,
        ExcBusErr          = 2'd2,
        ExcTimeout         = 2'd3
    } exc_cause_e;

    // funct3[1:0] encodes the access size: byte, half, word.
    function automatic logic is_misaligned(logic [2:0] funct3, logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/grant/response bus.
//  master : the memory stage (drives req/we/addr/be/wdata)
//  slave  : the memory (drives gnt/rvalid/rdata/err)
interface mem_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/mem_access_align.sv
// Combinational lane handling for one load/store.
//  funct3_i     : access size / signedness
//  addr_lo_i    : byte offset within the word
//  store_data_i : rs2 value
//  load_word_i  : raw word returned by memory
//  be_o         : byte enables for the store
//  wdata_o      : store data replicated across all lanes
//  load_data_o  : selected and extended load value
module mem_access_align (
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel    = load_word_i[{addr_lo_i, 3'b000} +: 8];
        half_sel    = addr_lo_i[1] ? load_word_i[31:16] : load_word_i[15:0];
        be_o        = 4'hF;
        wdata_o     = store_data_i;
        load_data_o = load_word_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_o        = 4'b0001 << addr_lo_i;
                wdata_o     = {4{store_data_i[7:0]}};
                load_data_o = funct3_i[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                be_o        = 4'b0011 << addr_lo_i;
                wdata_o     = {2{store_data_i[15:0]}};
                load_data_o = funct3_i[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage: runs at most one load/store on the dmem bus per accepted instruction
// and delivers one registered result (valid_o pulse) to writeback.
//  clk_i, rst_i    : clock, asynchronous active-high reset
//  valid_i/ready_o : upstream handshake; accepted only while idle
//  control_i, alu_i, mem_data_i, pc_plus4_i, addr_rd_i : execute-stage outputs
//  dmem            : data-memory bus (master side)
//  valid_o, control_o, addr_rd_o, pc_plus4_o, result_o, exc_o, exc_cause_o : writeback
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  control_t    control_i,
    input  logic [31:0] alu_i,
    input  logic [31:0] mem_data_i,
    input  logic [31:0] pc_plus4_i,
    input  logic [4:0]  addr_rd_i,
    mem_access_if.master dmem,
    output logic        valid_o,
    output control_t    control_o,
    output logic [4:0]  addr_rd_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] result_o,
    output logic        exc_o,
    output logic [1:0]  exc_cause_o
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    mem_state_e  state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    control_t    op_ctrl_q, op_ctrl_d;
    logic [31:0] op_addr_q, op_addr_d;
    logic [31:0] op_data_q, op_data_d;
    logic [31:0] op_pc4_q, op_pc4_d;
    logic [4:0]  op_rd_q, op_rd_d;
    logic        valid_q, valid_d;
    control_t    control_q, control_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;
    exc_cause_e  cause_q, cause_d;

    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        timeout_hit;
    logic        resp_done;
    logic        timed_out;

    mem_access_align u_align (
        .funct3_i     (op_ctrl_q.mem_funct3),
        .addr_lo_i    (op_addr_q[1:0]),
        .store_data_i (op_data_q),
        .load_word_i  (dmem.rdata),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .load_data_o  (al_load)
    );

    // cnt_q equals the index of the current REQ/WAIT cycle; abort on the last allowed one.
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_ctrl_d = op_ctrl_q;
        op_addr_d = op_addr_q;
        op_data_d = op_data_q;
        op_pc4_d  = op_pc4_q;
        op_rd_d   = op_rd_q;
        valid_d   = 1'b0;
        control_d = control_q;
        rd_d      = rd_q;
        pc4_d     = pc4_q;
        result_d  = result_q;
        exc_d     = exc_q;
        cause_d   = cause_q;
        resp_done = 1'b0;
        timed_out = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (valid_i) begin
                    if (!(control_i.mem_read || control_i.mem_write)) begin
                        valid_d   = 1'b1;
                        control_d = control_i;
                        rd_d      = addr_rd_i;
                        pc4_d     = pc_plus4_i;
                        result_d  = alu_i;
                        exc_d     = 1'b0;
                        cause_d   = ExcLoadMisaligned;
                    end else if (is_misaligned(control_i.mem_funct3, alu_i[1:0])) begin
                        valid_d   = 1'b1;
                        control_d = control_i;
                        rd_d      = addr_rd_i;
                        pc4_d     = pc_plus4_i;
                        result_d  = '0;
                        exc_d     = 1'b1;
                        cause_d   = control_i.mem_write ? ExcStoreMisaligned : ExcLoadMisaligned;
                    end else begin
                        state_d   = StReq;
                        cnt_d     = '0;
                        op_ctrl_d = control_i;
                        op_addr_d = alu_i;
                        op_data_d = mem_data_i;
                        op_pc4_d  = pc_plus4_i;
                        op_rd_d   = addr_rd_i;
                    end
                end
            end
            StReq: begin
                cnt_d = cnt_q + CntW'(1);
                // A same-cycle response wins over the timeout; a bare grant does not.
                if (dmem.gnt && dmem.rvalid) begin
                    resp_done = 1'b1;
                end else if (timeout_hit) begin
                    timed_out = 1'b1;
                end else if (dmem.gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q + CntW'(1);
                if (dmem.rvalid) begin
                    resp_done = 1'b1;
                end else if (timeout_hit) begin
                    timed_out = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (resp_done || timed_out) begin
            state_d   = StIdle;
            valid_d   = 1'b1;
            control_d = op_ctrl_q;
            rd_d      = op_rd_q;
            pc4_d     = op_pc4_q;
            exc_d     = timed_out || dmem.err;
            result_d  = (timed_out || dmem.err || op_ctrl_q.mem_write) ? '0 : al_load;
            cause_d   = timed_out ? ExcTimeout : (dmem.err ? ExcBusErr : ExcLoadMisaligned);
        end
    end

    // Bus outputs are decoded from state so an async reset drops req immediately.
    assign ready_o    = (state_q == StIdle);
    assign dmem.req   = (state_q == StReq);
    assign dmem.we    = dmem.req && op_ctrl_q.mem_write;
    assign dmem.addr  = dmem.req ? {op_addr_q[31:2], 2'b00} : '0;
    assign dmem.be    = dmem.req ? al_be : '0;
    assign dmem.wdata = dmem.req ? al_wdata : '0;

    assign valid_o     = valid_q;
    assign control_o   = control_q;
    assign addr_rd_o   = rd_q;
    assign pc_plus4_o  = pc4_q;
    assign result_o    = result_q;
    assign exc_o       = exc_q;
    assign exc_cause_o = cause_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_ctrl_q <= '0;
            op_addr_q <= '0;
            op_data_q <= '0;
            op_pc4_q  <= '0;
            op_rd_q   <= '0;
            valid_q   <= 1'b0;
            control_q <= MI_ADDI;
            rd_q      <= '0;
            pc4_q     <= '0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            cause_q   <= ExcLoadMisaligned;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_ctrl_q <= op_ctrl_d;
            op_addr_q <= op_addr_d;
            op_data_q <= op_data_d;
            op_pc4_q  <= op_pc4_d;
            op_rd_q   <= op_rd_d;
            valid_q   <= valid_d;
            control_q <= control_d;
            rd_q      <= rd_d;
            pc4_q     <= pc4_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
            cause_q   <= cause_d;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: the driver issues instructions and plays the memory,
// pushing the reference model's expected writeback record; a monitor pops on valid_o.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int TO = 6;

    typedef struct {
        control_t    ctrl;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] result;
        logic        exc;
        logic [1:0]  cause;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    control_t    control_i = '0;
    logic [31:0] alu_i = '0;
    logic [31:0] mem_data_i = '0;
    logic [31:0] pc_plus4_i = '0;
    logic [4:0]  addr_rd_i = '0;
    logic        valid_o;
    control_t    control_o;
    logic [4:0]  addr_rd_o;
    logic [31:0] pc_plus4_o;
    logic [31:0] result_o;
    logic        exc_o;
    logic [1:0]  exc_cause_o;

    mem_access_if dmem_if ();

    mem_access #(.TIMEOUT_CYC(TO)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .control_i   (control_i),
        .alu_i       (alu_i),
        .mem_data_i  (mem_data_i),
        .pc_plus4_i  (pc_plus4_i),
        .addr_rd_i   (addr_rd_i),
        .dmem        (dmem_if),
        .valid_o     (valid_o),
        .control_o   (control_o),
        .addr_rd_o   (addr_rd_o),
        .pc_plus4_o  (pc_plus4_o),
        .result_o    (result_o),
        .exc_o       (exc_o),
        .exc_cause_o (exc_cause_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    exp_t e_mon;
    logic [2:0] ld_f3[5];
    logic [2:0] st_f3[3];

    function automatic void chk(input bit ok, input string name, input string got,
                                input string want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, want %s", name, got, want);
    endfunction

    function automatic control_t mk_ctrl(input logic rd_en, input logic wr_en,
                                         input logic [2:0] f3);
        control_t c;
        c            = '0;
        c.reg_write  = rd_en || !wr_en;
        c.alu_op     = 4'($urandom_range(0, 15));
        c.alu_src    = 1'($urandom_range(0, 1));
        c.mem_read   = rd_en;
        c.mem_write  = wr_en;
        c.mem_funct3 = f3;
        return c;
    endfunction

    // Reference model: expected writeback record, bus lane values and latency in cycles.
    function automatic void model(input control_t c, input logic [31:0] alu, rs2, pc4,
                                  input logic [4:0] rd, input logic [31:0] rdata,
                                  input logic err, input int g, input int r,
                                  output exp_t e, output bit bus, output logic [3:0] be,
                                  output logic [31:0] wd, output int lat);
        int unsigned size, off;
        logic [31:0] mask, raw;
        e.ctrl = c; e.rd = rd; e.pc4 = pc4; e.result = '0; e.exc = 1'b0; e.cause = 2'd0;
        e.cyc = 0;
        bus = 0; be = '0; wd = '0; lat = 1;
        size = (c.mem_funct3[1:0] == 2'd0) ? 1 : (c.mem_funct3[1:0] == 2'd1) ? 2 : 4;
        off  = alu % 4;
        mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
        if (!(c.mem_read || c.mem_write)) begin
            e.result = alu;
        end else if (alu % size != 0) begin
            e.exc   = 1'b1;
            e.cause = c.mem_write ? 2'd1 : 2'd0;
        end else begin
            bus = 1;
            be  = 4'(((32'd1 << size) - 32'd1) << off);
            wd  = (size == 1) ? 32'(rs2[7:0]) * 32'h0101_0101 :
                  (size == 2) ? 32'(rs2[15:0]) * 32'h0001_0001 : rs2;
            if (g + r <= TO - 1) begin
                lat = g + r + 2;
                if (err) begin
                    e.exc = 1'b1; e.cause = 2'd2;
                end else if (!c.mem_write) begin
                    raw = (rdata >> (8 * off)) & mask;
                    if (!c.mem_funct3[2] && size < 4 && raw[8 * size - 1]) raw = raw | ~mask;
                    e.result = raw;
                end
            end else begin
                lat = TO + 1;
                e.exc = 1'b1; e.cause = 2'd3;
            end
        end
    endfunction

    function automatic bit reset_ok();
        return ready_o && !valid_o && control_o == MI_ADDI && addr_rd_o == 5'd0 &&
               pc_plus4_o == 32'd0 && result_o == 32'd0 && !exc_o && exc_cause_o == 2'd0 &&
               !dmem_if.req && !dmem_if.we && dmem_if.addr == 32'd0 && dmem_if.be == 4'd0 &&
               dmem_if.wdata == 32'd0;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) chk(1'b0, "ready_wait", "ready_o=0 after 50 cycles", "ready_o=1");
    endtask

    task automatic run_op(input control_t c, input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [31:0] pc4, input logic [4:0] rd, input int g,
                          input int r, input logic err, input logic [31:0] rdata);
        exp_t        e;
        bit          bus, done, in_wait;
        logic [3:0]  be;
        logic [31:0] wd;
        int          lat, idx;
        wait_ready();
        model(c, alu, rs2, pc4, rd, rdata, err, g, r, e, bus, be, wd, lat);
        control_i = c; alu_i = alu; mem_data_i = rs2; pc_plus4_i = pc4; addr_rd_i = rd;
        valid_i = 1'b1;
        e.cyc = cyc + lat;
        exp_q.push_back(e);
        @(negedge clk);
        valid_i = 1'b0;
        if (!bus) begin
            chk(!dmem_if.req && ready_o, "no_req",
                $sformatf("req=%0b ready=%0b", dmem_if.req, ready_o), "req=0 ready=1");
            return;
        end
        idx = 0; done = 0; in_wait = 0;
        while (!done && idx < TO) begin
            if (!in_wait)
                chk(dmem_if.req && !ready_o && dmem_if.we == c.mem_write &&
                    dmem_if.addr == {alu[31:2], 2'b00} && dmem_if.be == be &&
                    dmem_if.wdata == wd, "req_hold",
                    $sformatf("req=%0b rdy=%0b we=%0b addr=%h be=%b wdata=%h", dmem_if.req,
                              ready_o, dmem_if.we, dmem_if.addr, dmem_if.be, dmem_if.wdata),
                    $sformatf("req=1 rdy=0 we=%0b addr=%h be=%b wdata=%h", c.mem_write,
                              {alu[31:2], 2'b00}, be, wd));
            else
                chk(!dmem_if.req && !ready_o, "wait_state",
                    $sformatf("req=%0b ready=%0b", dmem_if.req, ready_o), "req=0 ready=0");
            dmem_if.gnt    = !in_wait && idx == g;
            dmem_if.rvalid = (!in_wait && idx == g && r == 0) || (in_wait && idx == g + r);
            dmem_if.err    = dmem_if.rvalid ? err : 1'($urandom_range(0, 1));
            dmem_if.rdata  = dmem_if.rvalid ? rdata : $urandom;
            valid_i        = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (dmem_if.rvalid) done = 1;
            if (dmem_if.gnt) in_wait = 1;
            idx++;
        end
        dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0; dmem_if.err = 1'b0; valid_i = 1'b0;
        chk(ready_o && !dmem_if.req, "idle_after",
            $sformatf("ready=%0b req=%0b", ready_o, dmem_if.req), "ready=1 req=0");
    endtask

    // Monitor: every valid_o pulse must match the oldest expectation, on the expected cycle.
    always @(negedge clk) begin
        if (!rst && valid_o) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_valid", $sformatf("valid_o result=%h", result_o),
                    "no output");
            end else begin
                e_mon = exp_q.pop_front();
                chk(control_o == e_mon.ctrl && addr_rd_o == e_mon.rd &&
                    pc_plus4_o == e_mon.pc4 && result_o == e_mon.result &&
                    exc_o == e_mon.exc && exc_cause_o == e_mon.cause && cyc == e_mon.cyc,
                    "writeback",
                    $sformatf("ctrl=%h rd=%0d pc4=%h res=%h exc=%0b cause=%0d cyc=%0d",
                              control_o, addr_rd_o, pc_plus4_o, result_o, exc_o,
                              exc_cause_o, cyc),
                    $sformatf("ctrl=%h rd=%0d pc4=%h res=%h exc=%0b cause=%0d cyc=%0d",
                              e_mon.ctrl, e_mon.rd, e_mon.pc4, e_mon.result, e_mon.exc,
                              e_mon.cause, e_mon.cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want $finish");
        $fatal(1);
    end

    initial begin
        control_t c;
        logic [31:0] a;
        int kind;
        ld_f3[0] = F3_LB; ld_f3[1] = F3_LH; ld_f3[2] = F3_LW; ld_f3[3] = F3_LBU;
        ld_f3[4] = F3_LHU;
        st_f3[0] = 3'b000; st_f3[1] = 3'b001; st_f3[2] = 3'b010;
        dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0; dmem_if.rdata = '0; dmem_if.err = 1'b0;

        repeat (2) @(negedge clk);
        chk(reset_ok(), "reset_state", $sformatf("ready=%0b valid=%0b ctrl=%h req=%0b",
            ready_o, valid_o, control_o, dmem_if.req), "idle, zero outputs, ctrl=MI_ADDI");
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_op(mk_ctrl(0, 0, 3'b000), 32'h0000_1234, 32'h5, 32'h44, 5'd3, 0, 0, 0, 32'h0);
        run_op(mk_ctrl(1, 0, F3_LB), 32'h103, 32'h0, 32'h48, 5'd4, 0, 0, 0, 32'h80FF_FF7F);
        run_op(mk_ctrl(1, 0, F3_LBU), 32'h103, 32'h0, 32'h4C, 5'd5, 1, 1, 0, 32'h80FF_FF7F);
        run_op(mk_ctrl(0, 1, 3'b001), 32'h102, 32'hABCD, 32'h50, 5'd0, 0, 1, 0, 32'h0);
        run_op(mk_ctrl(1, 0, F3_LH), 32'h102, 32'h0, 32'h54, 5'd6, 1, 0, 0, 32'h8001_7FFF);
        run_op(mk_ctrl(1, 0, F3_LHU), 32'h100, 32'h0, 32'h58, 5'd7, 0, 0, 0, 32'h8001_8FFF);
        run_op(mk_ctrl(1, 0, F3_LW), 32'h102, 32'h0, 32'h5C, 5'd8, 0, 0, 0, 32'h0);
        run_op(mk_ctrl(0, 1, 3'b010), 32'h101, 32'h0, 32'h60, 5'd0, 0, 0, 0, 32'h0);
        run_op(mk_ctrl(0, 1, 3'b000), 32'h203, 32'h1234_56A5, 32'h64, 5'd0, 3, 1, 0, 32'h0);
        run_op(mk_ctrl(1, 0, F3_LW), 32'h300, 32'h0, 32'h68, 5'd9, 2, 1, 1, 32'hDEAD_BEEF);
        run_op(mk_ctrl(1, 0, F3_LW), 32'h400, 32'h0, 32'h6C, 5'd10, 100, 0, 0, 32'h0);

        // Stray response after the timeout must not produce an output.
        dmem_if.rvalid = 1'b1; dmem_if.err = 1'b1; dmem_if.rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_if.rvalid = 1'b0; dmem_if.err = 1'b0;
        @(negedge clk);
        chk(ready_o && !dmem_if.req, "stray_rvalid",
            $sformatf("ready=%0b req=%0b", ready_o, dmem_if.req), "ready=1 req=0");

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 2);
            a = $urandom;
            if (kind != 0 && $urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            if (kind == 0) c = mk_ctrl(0, 0, 3'($urandom_range(0, 7)));
            else if (kind == 1) c = mk_ctrl(1, 0, ld_f3[$urandom_range(0, 4)]);
            else c = mk_ctrl(0, 1, st_f3[$urandom_range(0, 2)]);
            run_op(c, a, $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 7) == 0, $urandom);
        end

        // Reset pulsed while waiting for a response: pending access is discarded.
        wait_ready();
        control_i = mk_ctrl(1, 0, F3_LW); alu_i = 32'h500; addr_rd_i = 5'd11; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        dmem_if.gnt = 1'b1;
        @(negedge clk);
        dmem_if.gnt = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk(!dmem_if.req && ready_o, "rst_mid_access",
            $sformatf("req=%0b ready=%0b", dmem_if.req, ready_o), "req=0 ready=1");
        @(negedge clk);
        rst = 1'b0;
        dmem_if.rvalid = 1'b1; dmem_if.rdata = 32'h1234_5678;
        @(negedge clk);
        dmem_if.rvalid = 1'b0;
        @(negedge clk);
        chk(reset_ok(), "post_reset_state", $sformatf("ready=%0b valid=%0b ctrl=%h res=%h",
            ready_o, valid_o, control_o, result_o), "idle, zero outputs, ctrl=MI_ADDI");

        run_op(mk_ctrl(0, 0, 3'b000), 32'hCAFE_F00D, 32'h0, 32'h70, 5'd12, 0, 0, 0, 32'h0);
        repeat (4) @(negedge clk);
        chk(exp_q.size() == 0, "drain", $sformatf("%0d pending", exp_q.size()), "0 pending");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
